// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - state codes, axis encodings and saturating step helpers for the sweep scheduler
package sweep_pkg;

  // State codes as they appear on STAT.
  typedef enum logic [2:0] {
    ST_MANUAL = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_PARK   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Which servo the scan is currently stepping.
  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_t;

  // Increment with saturation. The limit test happens before the add,
  // so the sum can never wrap.
  function automatic logic [31:0] step_up(input logic [31:0] pos,
                                          input logic [31:0] step,
                                          input logic [31:0] hi);
    if (pos <= hi - step) return pos + step;
    else                  return hi;
  endfunction

  // Decrement with saturation at the lower limit.
  function automatic logic [31:0] step_down(input logic [31:0] pos,
                                            input logic [31:0] step,
                                            input logic [31:0] lo);
    if (pos >= lo + step) return pos - step;
    else                  return lo;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge pulse generator for a debounced level input
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   level    : debounced input level
//   pulse    : high for the single cycle where level is 1 and was 0 the cycle before
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - two-axis servo sweep: scan H then V, keep the best ADC reading, park there
// Ports:
//   CLK, RST           : clock, synchronous active-high reset
//   BTN_L/R/U/D        : manual H-/H+/V+/V- (debounced levels, act on rising edge)
//   BTN_C              : start scan from MANUAL, abort while scanning
//   adc_req            : conversion request, high from SAMPLE entry until the valid cycle
//   adc_valid, V_in    : one-cycle ADC result strobe and data
//   servo_position_H/V : pulse widths for the PWM drivers
//   max_V_in           : best reading of the last/current scan
//   STAT               : state code
//   scan_done          : one-cycle pulse when parking completes
module sweep_scheduler
  import sweep_pkg::*;
#(
  parameter int unsigned POS_MIN       = 50000,
  parameter int unsigned POS_MAX       = 250000,
  parameter int unsigned POS_STEP      = 5000,
  parameter int unsigned POS_CENTER    = 150000,
  parameter int unsigned SETTLE_CYCLES = 2000000,
  parameter int          ADC_W         = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_L,
  input  logic             BTN_R,
  input  logic             BTN_U,
  input  logic             BTN_D,
  input  logic             BTN_C,
  output logic             adc_req,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] V_in,
  output logic [31:0]      servo_position_H,
  output logic [31:0]      servo_position_V,
  output logic [ADC_W-1:0] max_V_in,
  output logic [2:0]       STAT,
  output logic             scan_done
);

  localparam logic [31:0] P_MIN       = POS_MIN;
  localparam logic [31:0] P_MAX       = POS_MAX;
  localparam logic [31:0] P_STEP      = POS_STEP;
  localparam logic [31:0] P_CENTER    = POS_CENTER;
  localparam logic [31:0] SETTLE_LOAD = SETTLE_CYCLES - 1;

  state_t           state, state_next;
  axis_t            axis;
  logic [31:0]      pos_h, pos_v;
  logic [31:0]      best_h, best_v;
  logic [31:0]      cnt;
  logic [ADC_W-1:0] max_v;

  logic e_l, e_r, e_u, e_d, e_c;

  edge_detect u_edge_l (.clk(CLK), .rst(RST), .level(BTN_L), .pulse(e_l));
  edge_detect u_edge_r (.clk(CLK), .rst(RST), .level(BTN_R), .pulse(e_r));
  edge_detect u_edge_u (.clk(CLK), .rst(RST), .level(BTN_U), .pulse(e_u));
  edge_detect u_edge_d (.clk(CLK), .rst(RST), .level(BTN_D), .pulse(e_d));
  edge_detect u_edge_c (.clk(CLK), .rst(RST), .level(BTN_C), .pulse(e_c));

  // Sample-cycle helpers. The "eff" bests fold in the current sample so that
  // the end-of-axis jump uses the final point when that point is the new best.
  logic [31:0] cur_pos;
  logic        better;
  logic [31:0] best_h_eff, best_v_eff;

  always_comb begin
    cur_pos    = (axis == AXIS_V) ? pos_v : pos_h;
    better     = adc_valid && (V_in > max_v);
    best_h_eff = best_h;
    best_v_eff = best_v;
    if (better && axis == AXIS_H) best_h_eff = pos_h;
    if (better && axis == AXIS_V) best_v_eff = pos_v;
  end

  // Next-state logic; a BTN_C edge aborts any scanning state.
  always_comb begin
    state_next = state;
    case (state)
      ST_MANUAL: if (e_c) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (e_c)            state_next = ST_MANUAL;
        else if (cnt == '0) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (e_c) state_next = ST_MANUAL;
        else if (adc_valid) begin
          if (cur_pos < P_MAX || axis == AXIS_H) state_next = ST_SETTLE;
          else                                   state_next = ST_PARK;
        end
      end
      ST_PARK: begin
        if (e_c)            state_next = ST_MANUAL;
        else if (cnt == '0) state_next = ST_DONE;
      end
      ST_DONE:   state_next = ST_MANUAL;
      default:   state_next = ST_MANUAL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_MANUAL;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      axis      <= AXIS_H;
      pos_h     <= P_CENTER;
      pos_v     <= P_CENTER;
      best_h    <= P_CENTER;
      best_v    <= P_CENTER;
      max_v     <= '0;
      cnt       <= '0;
      adc_req   <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      // Request stays up exactly while the FSM is waiting in SAMPLE.
      adc_req   <= (state_next == ST_SAMPLE);
      scan_done <= (state == ST_PARK) && (state_next == ST_DONE);

      // Reload on entry to a waiting state so it lasts SETTLE_CYCLES cycles.
      if (state_next != state && (state_next == ST_SETTLE || state_next == ST_PARK))
        cnt <= SETTLE_LOAD;
      else if (cnt != '0)
        cnt <= cnt - 32'd1;

      case (state)
        ST_MANUAL: begin
          if (e_c) begin
            axis   <= AXIS_H;
            pos_h  <= P_MIN;
            best_h <= P_MIN;
            best_v <= pos_v;
            max_v  <= '0;
          end else begin
            if (e_r && !e_l)      pos_h <= step_up(pos_h, P_STEP, P_MAX);
            else if (e_l && !e_r) pos_h <= step_down(pos_h, P_STEP, P_MIN);
            if (e_u && !e_d)      pos_v <= step_up(pos_v, P_STEP, P_MAX);
            else if (e_d && !e_u) pos_v <= step_down(pos_v, P_STEP, P_MIN);
          end
        end
        ST_SAMPLE: begin
          if (!e_c && adc_valid) begin
            if (better) max_v <= V_in;
            best_h <= best_h_eff;
            best_v <= best_v_eff;
            if (cur_pos < P_MAX) begin
              if (axis == AXIS_H) pos_h <= pos_h + P_STEP;
              else                pos_v <= pos_v + P_STEP;
            end else if (axis == AXIS_H) begin
              // V sweep runs with H parked at its best point.
              pos_h <= best_h_eff;
              pos_v <= P_MIN;
              axis  <= AXIS_V;
            end else begin
              pos_v <= best_v_eff;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign servo_position_H = pos_h;
  assign servo_position_V = pos_v;
  assign max_V_in         = max_v;
  assign STAT             = state;

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - self-checking bench for sweep_scheduler
module tb_sweep_scheduler;

  localparam int MINP = 10, MAXP = 50, STEP = 10, CTR = 30, SETTLE = 4, ADC_W = 12;
  localparam int NPTS = (MAXP - MINP) / STEP + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_l, btn_r, btn_u, btn_d, btn_c;
  logic             adc_req, adc_valid, scan_done;
  logic [ADC_W-1:0] v_in, max_v;
  logic [31:0]      pos_h, pos_v;
  logic [2:0]       stat;

  sweep_scheduler #(
    .POS_MIN(MINP), .POS_MAX(MAXP), .POS_STEP(STEP), .POS_CENTER(CTR),
    .SETTLE_CYCLES(SETTLE), .ADC_W(ADC_W)
  ) dut (
    .CLK(clk), .RST(rst),
    .BTN_L(btn_l), .BTN_R(btn_r), .BTN_U(btn_u), .BTN_D(btn_d), .BTN_C(btn_c),
    .adc_req(adc_req), .adc_valid(adc_valid), .V_in(v_in),
    .servo_position_H(pos_h), .servo_position_V(pos_v),
    .max_V_in(max_v), .STAT(stat), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  int          vals [2*NPTS];
  int          idx = 0;
  logic        adc_en = 1'b1;
  int          req_cnt = 0, done_cnt = 0, wait_cnt = 0, rk;
  logic        req_prev = 1'b0;
  logic [31:0] obs_h [2*NPTS];
  logic [31:0] obs_v [2*NPTS];
  int          h_m, v_m;

  // ADC model: answers 3 cycles after a request with the next table value,
  // and logs where the servos were at each conversion.
  initial begin
    adc_valid = 1'b0;
    v_in = '0;
    forever begin
      @(posedge clk); #2;
      if (adc_req === 1'b1 && !req_prev) req_cnt++;
      req_prev = (adc_req === 1'b1);
      if (scan_done === 1'b1) done_cnt++;
      if (adc_valid) begin
        adc_valid = 1'b0;
        wait_cnt = 0;
      end else if (adc_req === 1'b1 && adc_en) begin
        wait_cnt++;
        if (wait_cnt == 3) begin
          rk = (idx < 2*NPTS) ? idx : 0;
          v_in = 12'(vals[rk]);
          if (idx < 2*NPTS) begin
            obs_h[idx] = pos_h;
            obs_v[idx] = pos_v;
          end
          idx++;
          adc_valid = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic lv);
    case (b)
      0: btn_l = lv;
      1: btn_r = lv;
      2: btn_u = lv;
      3: btn_d = lv;
      default: btn_c = lv;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); tick();
    set_btn(b, 1'b0); tick();
  endtask

  function automatic int clampstep(input int p, input int d);
    int n;
    n = p + d;
    if (n > MAXP) n = MAXP;
    if (n < MINP) n = MINP;
    return n;
  endfunction

  // Full scan from MANUAL; expected outcome is the first strict maximum of
  // the H samples, then of the V samples measured against that maximum.
  task automatic run_scan(input string tag);
    int v0, bh, bv, mx, d0, r0;
    v0 = v_m; d0 = done_cnt; r0 = req_cnt; idx = 0;
    btn_c = 1'b1; tick(); btn_c = 1'b0;
    check({tag, "_start_stat"}, 32'(stat), 32'd1);
    check({tag, "_start_h"}, pos_h, 32'(MINP));
    for (int i = 0; i < 2000 && scan_done !== 1'b1; i++) tick();
    check({tag, "_done_pulse"}, 32'(scan_done), 32'd1);
    check({tag, "_done_stat"}, 32'(stat), 32'd4);
    tick();
    check({tag, "_back_manual"}, 32'(stat), 32'd0);
    mx = 0; bh = MINP; bv = v0;
    for (int i = 0; i < NPTS; i++)
      if (vals[i] > mx) begin mx = vals[i]; bh = MINP + i*STEP; end
    for (int i = 0; i < NPTS; i++)
      if (vals[NPTS+i] > mx) begin mx = vals[NPTS+i]; bv = MINP + i*STEP; end
    check({tag, "_final_h"}, pos_h, 32'(bh));
    check({tag, "_final_v"}, pos_v, 32'(bv));
    check({tag, "_max"}, 32'(max_v), 32'(mx));
    check({tag, "_req_count"}, 32'(req_cnt - r0), 32'(2*NPTS));
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < NPTS; i++) begin
      check({tag, "_grid_h"}, obs_h[i], 32'(MINP + i*STEP));
      check({tag, "_grid_hv"}, obs_v[i], 32'(v0));
      check({tag, "_grid_vh"}, obs_h[NPTS+i], 32'(bh));
      check({tag, "_grid_v"}, obs_v[NPTS+i], 32'(MINP + i*STEP));
    end
    h_m = bh; v_m = bv;
  endtask

  initial begin
    int b;
    logic all_high;
    rst = 1'b1; btn_l = 0; btn_r = 0; btn_u = 0; btn_d = 0; btn_c = 0;
    for (int i = 0; i < 2*NPTS; i++) vals[i] = 0;
    tick(); tick();
    check("rst_h", pos_h, 32'(CTR));
    check("rst_v", pos_v, 32'(CTR));
    check("rst_stat", 32'(stat), 32'd0);
    check("rst_req", 32'(adc_req), 32'd0);
    check("rst_max", 32'(max_v), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    rst = 1'b0; tick();
    h_m = CTR; v_m = CTR;

    btn_r = 1'b1; repeat (20) tick(); btn_r = 1'b0; tick();
    h_m = clampstep(h_m, STEP);
    check("hold_r_single_step", pos_h, 32'(h_m));
    for (int i = 0; i < 4; i++) begin
      press(1);
      h_m = clampstep(h_m, STEP);
      check("press_r", pos_h, 32'(h_m));
    end
    check("sat_max", pos_h, 32'(MAXP));
    btn_l = 1'b1; btn_r = 1'b1; tick(); btn_l = 1'b0; btn_r = 1'b0; tick();
    check("lr_same_cycle", pos_h, 32'(h_m));
    btn_u = 1'b1; btn_d = 1'b1; tick(); btn_u = 1'b0; btn_d = 1'b0; tick();
    check("ud_same_cycle", pos_v, 32'(v_m));

    vals = '{100, 400, 900, 900, 200, 50, 950, 300, 950, 10};
    run_scan("plan");
    check("plan_h30", pos_h, 32'd30);
    check("plan_v20", pos_v, 32'd20);
    check("plan_max950", 32'(max_v), 32'd950);

    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 6; j++) begin
        b = $urandom_range(0, 3);
        press(b);
        case (b)
          0: h_m = clampstep(h_m, -STEP);
          1: h_m = clampstep(h_m, STEP);
          2: v_m = clampstep(v_m, STEP);
          default: v_m = clampstep(v_m, -STEP);
        endcase
        check("rand_manual_h", pos_h, 32'(h_m));
        check("rand_manual_v", pos_v, 32'(v_m));
      end
      for (int i = 0; i < 2*NPTS; i++)
        vals[i] = (it % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 4095);
      run_scan("rand_scan");
    end

    for (int i = 0; i < 6; i++) begin press(0); h_m = clampstep(h_m, -STEP); end
    check("sat_min", pos_h, 32'(MINP));

    adc_en = 1'b0; idx = 0;
    btn_c = 1'b1; tick(); btn_c = 1'b0;
    for (int i = 0; i < 50 && stat !== 3'd2; i++) tick();
    check("noval_enter_sample", 32'(stat), 32'd2);
    all_high = 1'b1;
    for (int i = 0; i < 100; i++) begin tick(); all_high &= (adc_req === 1'b1); end
    check("noval_req_held", 32'(all_high), 32'd1);
    check("noval_stat", 32'(stat), 32'd2);
    check("noval_h", pos_h, 32'(MINP));
    btn_c = 1'b1; tick();
    check("noval_abort_stat", 32'(stat), 32'd0);
    check("noval_abort_req", 32'(adc_req), 32'd0);
    btn_c = 1'b0; tick();
    adc_en = 1'b1; h_m = MINP;

    vals = '{100, 400, 900, 900, 200, 50, 950, 300, 950, 10};
    idx = 0; b = done_cnt;
    btn_c = 1'b1; tick(); btn_c = 1'b0;
    for (int i = 0; i < 200 && !(stat === 3'd1 && pos_h === 32'd30); i++) tick();
    check("abort_reach_3rd_settle", pos_h, 32'd30);
    btn_c = 1'b1; tick();
    check("abort_stat", 32'(stat), 32'd0);
    check("abort_h", pos_h, 32'd30);
    check("abort_req", 32'(adc_req), 32'd0);
    check("abort_max_kept", 32'(max_v), 32'd400);
    btn_c = 1'b0; repeat (10) tick();
    check("abort_no_done", 32'(done_cnt - b), 32'd0);
    h_m = 30;
    press(2); v_m = clampstep(v_m, STEP);
    check("abort_then_u", pos_v, 32'(v_m));

    idx = 0;
    btn_c = 1'b1; tick(); btn_c = 1'b0;
    for (int i = 0; i < 500 && idx < NPTS + 2; i++) tick();
    check("midv_reached", 32'(idx >= NPTS + 2), 32'd1);
    rst = 1'b1; tick();
    check("midv_rst_h", pos_h, 32'(CTR));
    check("midv_rst_v", pos_v, 32'(CTR));
    check("midv_rst_max", 32'(max_v), 32'd0);
    check("midv_rst_stat", 32'(stat), 32'd0);
    check("midv_rst_req", 32'(adc_req), 32'd0);
    rst = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
Sequences the two-axis servo sweep of the solar-panel optimizer. It steps the H axis, then the V axis, through their pulse-width ranges. At each point it waits for mechanical settling, requests one ADC conversion and keeps the position with the highest panel voltage, then parks both servos there. It sits between the debounced buttons/ADC front end and the PWM servo drivers, and replaces ad-hoc button-driven positioning with a scheduled scan plus a manual fallback.

Parameters:
POS_MIN, 50000, minimum servo pulse width in CLK cycles (0.5 ms @100 MHz)
POS_MAX, 250000, maximum pulse width in CLK cycles
POS_STEP, 5000, scan and manual step in CLK cycles; (POS_MAX-POS_MIN) is a multiple of POS_STEP
POS_CENTER, 150000, reset position of both axes
SETTLE_CYCLES, 2000000, wait after each move before sampling (20 ms)
ADC_W, 12, ADC sample width

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
BTN_L  in  1  debounced, level; manual H decrement
BTN_R  in  1  manual H increment
BTN_U  in  1  manual V increment
BTN_D  in  1  manual V decrement
BTN_C  in  1  start scan (from MANUAL) / abort scan (while scanning)
adc_req  out  1  conversion request
adc_valid  in  1  one-cycle strobe, V_in valid
V_in  in  ADC_W  ADC result
servo_position_H  out  32  H pulse width to PWM driver
servo_position_V  out  32  V pulse width to PWM driver
max_V_in  out  ADC_W  best voltage of the last/current scan
STAT  out  3  state code
scan_done  out  1  one-cycle pulse when parking completes

Behaviour:
- Reset: positions=POS_CENTER, max_V_in=0, adc_req=0, scan_done=0, STAT=MANUAL, all counters and edge registers cleared. Reset mid-scan aborts immediately, with no parking.
- Buttons are edge-detected internally (registered previous value). Actions occur on the 0->1 cycle only, one step per press.
- STAT codes: 0 MANUAL, 1 SETTLE, 2 SAMPLE, 3 PARK, 4 DONE. An internal axis flag (0=H, 1=V) qualifies SETTLE/SAMPLE.
- MANUAL:
  - L/R/U/D edge: position -/+ POS_STEP, saturating at POS_MIN/POS_MAX. A press at a limit leaves the position unchanged.
  - Simultaneous L and R edges: no change; same for U and D.
  - C edge: axis=H, H=POS_MIN, V unchanged, max_V_in=0, best_H=POS_MIN, best_V=V, then SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then SAMPLE. The counter reloads on entry.
- SAMPLE:
  - adc_req rises on entry and stays high until the cycle adc_valid=1; it is 0 the following cycle. adc_valid outside SAMPLE is ignored.
  - On adc_valid, if V_in > max_V_in (strict): max_V_in<=V_in and best_<axis><=current position. Ties keep the earliest point.
  - If position < POS_MAX: position += POS_STEP, then SETTLE.
  - Else, axis H: H<=best_H, V<=POS_MIN, axis=V, then SETTLE. The V scan starts from the H best and max_V_in is not cleared.
  - Else, axis V: V<=best_V, then PARK.
- PARK: waits SETTLE_CYCLES, then DONE with scan_done pulsed for one cycle.
- DONE: holds positions. The next cycle goes to MANUAL; buttons are then active again.
- BTN_C edge in SETTLE/SAMPLE/PARK: abort to MANUAL, adc_req<=0, positions hold their current values, max_V_in keeps its value, no scan_done.
- Direction buttons are ignored outside MANUAL.
- Points per axis = (POS_MAX-POS_MIN)/POS_STEP+1 (41 at defaults).
- Worst-case scan length ≈ 83·SETTLE_CYCLES plus ADC latency.
- Position arithmetic is 32-bit unsigned, and the comparison is done before the add, so positions never overflow.
- Outputs are registered; a position change is visible the cycle after the triggering event.

Decomposition:
- Package sweep_pkg holds the STAT state localparams (ST_MANUAL..ST_DONE) and the axis encodings.
- One sub-module, edge_detect (rising-edge pulse, synchronous reset), is instantiated five times.
- The settle counter stays inline.

Test Plan:
Bench uses POS_MIN=10, POS_MAX=50, POS_STEP=10, POS_CENTER=30, SETTLE_CYCLES=4, and an ADC model with valid 3 cycles after req.
- Reset held 2 cycles -> positions 30/30, STAT=0, adc_req=0, max_V_in=0.
- BTN_R held 20 cycles -> H=40 (single step). Then 3 more presses -> H=50; further press stays 50. BTN_L and BTN_R asserted in the same cycle -> no change.
- BTN_C. ADC returns V_in = H-dependent [100,400,900,900,200] for H=10..50, then V-dependent [50,950,300,950,10] -> best_H=30 (first of tie), V scan picks V=20 (950, first of tie). Then PARK, scan_done pulse, final H=30, V=20, max_V_in=950, exactly 10 adc_req assertions.
- adc_valid never asserted in SAMPLE for 100 cycles -> adc_req stays high, position unchanged, STAT=2.
- BTN_C edge during the 3rd H SETTLE -> STAT=0 next cycle, H=30, adc_req=0, no scan_done. BTN_U then moves V by +10.
- RST asserted mid-V scan -> next cycle positions 30/30, max_V_in=0, STAT=0.
